// File: rtl/simon_pkg.sv
// Shared Simon 32/64 constants and helpers.
// Used by the key schedule and the encrypt round datapath.
//   SIMON32_ROUNDS   : rounds per block (one round key each)
//   SIMON32_WORD     : word width in bits
//   SIMON32_KEYWORDS : master-key words (size of the key-schedule window)
//   SIMON_Z0         : z0 constant sequence, first sequence bit in the MSB
package simon_pkg;

  localparam int unsigned SIMON32_ROUNDS   = 32;
  localparam int unsigned SIMON32_WORD     = 16;
  localparam int unsigned SIMON32_KEYWORDS = 4;
  localparam int unsigned SIMON_Z0_LEN     = 62;

  // Written left to right exactly as the sequence is published, so bit j of
  // the sequence lives at SIMON_Z0[SIMON_Z0_LEN-1-j].
  localparam logic [SIMON_Z0_LEN-1:0] SIMON_Z0 =
      62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef logic [SIMON32_WORD-1:0] simon32_word_t;

  // Sequence bit j of z0, counted from the first (leftmost) bit.
  function automatic logic z0_bit(input logic [5:0] j);
    logic [5:0] pos;
    pos = 6'(SIMON_Z0_LEN - 1) - j;
    return SIMON_Z0[pos];
  endfunction

  // Rotate a word right by n bits (0 < n < word width).
  function automatic simon32_word_t ror16(input simon32_word_t x, input int unsigned n);
    return (x >> n) | (x << (SIMON32_WORD - n));
  endfunction

endpackage

// File: rtl/simon32s64_key_step.sv
// One Simon 32/64 key-schedule step, purely combinational.
// Produces the next key word k[i+4] from the sliding window.
//   w0    in  16  window word 0 (k[i])
//   w1    in  16  window word 1 (k[i+1])
//   w3    in  16  window word 3 (k[i+3])
//   z     in  1   z0 sequence bit for step i
//   knew  out 16  next key word k[i+4]
module simon32s64_key_step
  import simon_pkg::*;
(
  input  simon32_word_t w0,
  input  simon32_word_t w1,
  input  simon32_word_t w3,
  input  logic          z,
  output simon32_word_t knew
);

  simon32_word_t t1;
  simon32_word_t t2;

  always_comb begin
    t1   = ror16(w3, 3) ^ w1;
    t2   = t1 ^ ror16(t1, 1);
    // Constant c = 2^16 - 4 folded in as ~w0 ^ 3.
    knew = ~w0 ^ t2 ^ {{(SIMON32_WORD-1){1'b0}}, z} ^ 16'h0003;
  end

endmodule

// File: rtl/simon32s64_key_expand.sv
// Simon 32/64 key expansion: accepts a 64-bit master key and streams the
// 32 round keys k0..k31 in order over a valid/ready handshake, computing
// each new word on the fly from a 4-word sliding window.
//   clk         in  1   clock
//   rst         in  1   synchronous active-high reset
//   key_in      in  64  master key, k0 in [15:0] .. k3 in [63:48]
//   key_in_vld  in  1   master key valid
//   key_in_rdy  out 1   ready for a master key (idle)
//   rk_out      out 16  current round key
//   rk_idx      out 5   index of rk_out
//   rk_last     out 1   valid round key is the last one (idx 31)
//   rk_vld      out 1   round key valid
//   rk_rdy      in  1   consumer accepts round key
//   replay_req  in  1   only with SIMON_KEYEXP_REPLAY_EN: re-stream held key
// Optional feature macro: SIMON_KEYEXP_REPLAY_EN.
module simon32s64_key_expand
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_in_vld,
  output logic        key_in_rdy,
  output logic [15:0] rk_out,
  output logic [4:0]  rk_idx,
  output logic        rk_last,
  output logic        rk_vld,
  input  logic        rk_rdy
`ifdef SIMON_KEYEXP_REPLAY_EN
  ,
  input  logic        replay_req
`endif
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  localparam logic [4:0] LastIdx = 5'(SIMON32_ROUNDS - 1);

  logic [0:0]    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  simon32_word_t win_q [SIMON32_KEYWORDS];
  simon32_word_t win_d [SIMON32_KEYWORDS];
  simon32_word_t knew;
  logic          load;
  logic [63:0]   load_key;
  logic          advance;

`ifdef SIMON_KEYEXP_REPLAY_EN
  logic [63:0] held_q, held_d;
`endif

  simon32s64_key_step u_step (
    .w0   (win_q[0]),
    .w1   (win_q[1]),
    .w3   (win_q[3]),
    .z    (z0_bit({1'b0, idx_q})),
    .knew (knew)
  );

  // Load decision: a fresh key always wins over a replay request.
  always_comb begin
    load     = 1'b0;
    load_key = key_in;
`ifdef SIMON_KEYEXP_REPLAY_EN
    held_d   = held_q;
    if (state_q == StIdle) begin
      if (key_in_vld) begin
        load   = 1'b1;
        held_d = key_in;
      end else if (replay_req) begin
        load     = 1'b1;
        load_key = held_q;
      end
    end
`else
    load = (state_q == StIdle) && key_in_vld;
`endif
  end

  assign advance = (state_q == StStream) && rk_rdy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    if (load) begin
      for (int k = 0; k < int'(SIMON32_KEYWORDS); k++) begin
        win_d[k] = load_key[k*int'(SIMON32_WORD) +: SIMON32_WORD];
      end
      idx_d   = '0;
      state_d = StStream;
    end else if (advance) begin
      if (idx_q == LastIdx) begin
        // Window and index are left as-is; outputs are gated by rk_vld.
        state_d = StIdle;
      end else begin
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = win_q[3];
        win_d[3] = knew;
        idx_d    = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      for (int k = 0; k < int'(SIMON32_KEYWORDS); k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
    end
  end

`ifdef SIMON_KEYEXP_REPLAY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end
`endif

  // All outputs decode registered state only.
  assign key_in_rdy = (state_q == StIdle);
  assign rk_vld     = (state_q == StStream);
  assign rk_out     = win_q[0];
  assign rk_idx     = idx_q;
  assign rk_last    = (state_q == StStream) && (idx_q == LastIdx);

endmodule

// File: tb/tb_simon32s64_key_expand.sv
// Randomized self-checking bench for simon32s64_key_expand against a
// behavioural key-schedule model.
module tb_simon32s64_key_expand;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        key_in_vld;
  logic        key_in_rdy;
  logic [15:0] rk_out;
  logic [4:0]  rk_idx;
  logic        rk_last;
  logic        rk_vld;
  logic        rk_rdy;
  logic        replay_req;

  int n_total;
  int n_pass;

  logic [15:0] exp_rk [32];
  logic [63:0] held_model;

  localparam logic [63:0] KatKey = 64'h1918_1110_0908_0100;
  logic [15:0] kat [5];

  string z0_str = "11111010001001010110000111001101111101000100101011000011100110";

  simon32s64_key_expand dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_in_vld (key_in_vld),
    .key_in_rdy (key_in_rdy),
    .rk_out     (rk_out),
    .rk_idx     (rk_idx),
    .rk_last    (rk_last),
    .rk_vld     (rk_vld),
    .rk_rdy     (rk_rdy)
`ifdef SIMON_KEYEXP_REPLAY_EN
    ,
    .replay_req (replay_req)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [15:0] rot_r(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x};
    return d[n +: 16];
  endfunction

  // Straight from the published key-schedule recurrence.
  task automatic compute_model(input logic [63:0] key);
    logic [15:0] k [36];
    logic [15:0] t;
    for (int j = 0; j < 4; j++) k[j] = key[16*j +: 16];
    for (int i = 0; i < 32; i++) begin
      t = rot_r(k[i+3], 3) ^ k[i+1];
      t = t ^ rot_r(t, 1);
      k[i+4] = (~k[i]) ^ t ^ ((z0_str[i] == "1") ? 16'h1 : 16'h0) ^ 16'h3;
    end
    for (int i = 0; i < 32; i++) exp_rk[i] = k[i];
  endtask

  // mode: 0 key only, 1 replay only, 2 key and replay together.
  task automatic run_stream(input logic [63:0] key, input int mode, input int stall,
                            input bit hold, input logic [63:0] hold_key, input int abort_at);
    int  budget;
    int  idx;
    bit  done;
    bit  adv;
    if (mode != 1) held_model = key;
    compute_model(held_model);
    budget = 0;
    while (!key_in_rdy && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!key_in_rdy) check("rdy_wait", 32'd0, 32'd1);
    key_in     = key;
    key_in_vld = (mode != 1);
    replay_req = (mode != 0);
    rk_rdy     = ($urandom_range(99) >= 50);
    @(negedge clk);
    key_in_vld = hold;
    key_in     = hold ? hold_key : $urandom();
    replay_req = 1'b0;
    idx = 0; budget = 0; done = 0;
    while (!done && budget < 3000) begin
      check("stream", {key_in_rdy, rk_vld, rk_last, rk_idx, rk_out},
            {1'b0, 1'b1, idx == 31, 5'(idx), exp_rk[idx]});
      if (key == KatKey && mode == 0 && idx < 5) check("kat", {16'h0, rk_out}, {16'h0, kat[idx]});
      if (idx == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort", {key_in_rdy, rk_vld, rk_last, rk_idx, rk_out}, {1'b1, 1'b0, 1'b0, 21'h0});
        return;
      end
      rk_rdy = ($urandom_range(99) >= stall);
      adv    = rk_rdy;
      @(negedge clk);
      budget++;
      if (adv) begin
        if (idx == 31) done = 1;
        else idx++;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    if (stall == 0) check("cycles", budget, 32);
    check("end", {key_in_rdy, rk_vld, rk_last}, 3'b100);
  endtask

  initial begin
    logic [63:0] ka, kb;
    n_total = 0; n_pass = 0;
    kat[0] = 16'h0100; kat[1] = 16'h0908; kat[2] = 16'h1110;
    kat[3] = 16'h1918; kat[4] = 16'h71C3;
    held_model = '0;
    rst = 1'b1; key_in = '0; key_in_vld = 1'b0; rk_rdy = 1'b0; replay_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", {key_in_rdy, rk_vld, rk_last, rk_idx, rk_out}, {1'b1, 1'b0, 1'b0, 21'h0});
    rst = 1'b0;

    run_stream(KatKey, 0, 0, 1'b0, '0, -1);
    run_stream(KatKey, 0, 40, 1'b0, '0, -1);

    ka = {$urandom(), $urandom()};
    kb = {$urandom(), $urandom()};
    run_stream(ka, 0, 20, 1'b1, kb, -1);
    run_stream(kb, 0, 0, 1'b0, '0, -1);

    run_stream({$urandom(), $urandom()}, 0, 0, 1'b0, '0, 10);
    run_stream(KatKey, 0, 0, 1'b0, '0, -1);

    for (int n = 0; n < 100; n++) begin
      run_stream({$urandom(), $urandom()}, 0, (n % 3 == 0) ? 0 : 30, 1'b0, '0, -1);
    end

`ifdef SIMON_KEYEXP_REPLAY_EN
    ka = {$urandom(), $urandom()};
    run_stream(ka, 0, 0, 1'b0, '0, -1);
    run_stream({$urandom(), $urandom()}, 1, 25, 1'b0, '0, -1);
    run_stream({$urandom(), $urandom()}, 2, 25, 1'b0, '0, -1);
    run_stream('0, 1, 0, 1'b0, '0, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
